stopwatch_uart_tx: RTL

Serial reporter for the stopwatch display value. Watches the three BCD seconds digits and forces a report on request. Sends the value as an ASCII line "D2D1D0\r\n" over 8N1 UART on o_Tx. Sits beside the stopwatch core and drives the board's UART TX pin.

---
 rtl/stopwatch_uart_tx_pkg.sv | 31 +++
 rtl/uart_tx_byte.sv | 138 +++++++++++++
 rtl/stopwatch_uart_tx.sv | 118 +++++++++++
 3 files changed

// File: rtl/stopwatch_uart_tx_pkg.sv
// Shared constants for the stopwatch UART reporter: ASCII codes, message length,
// message/byte FSM state encodings and the BCD-to-ASCII helper.
// Latency: n/a (package). Backpressure: n/a.
// Optional feature macro (used by importers): STOPWATCH_UART_PARITY_EN.
package stopwatch_uart_tx_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int MSG_LEN = 5;

    // Message FSM encodings
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_SEND = 2'd1;
    localparam logic [1:0] M_WAIT = 2'd2;

    // Byte FSM encodings
    localparam logic [2:0] B_IDLE   = 3'd0;
    localparam logic [2:0] B_START  = 3'd1;
    localparam logic [2:0] B_DATA   = 3'd2;
    localparam logic [2:0] B_PARITY = 3'd3;
    localparam logic [2:0] B_STOP   = 3'd4;

    // Non-BCD nibbles are reported as '?' so a corrupted digit is visible on the line.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'b0000, d});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: 8 data bits LSB first, 1 stop bit (even parity bit before stop with STOPWATCH_UART_PARITY_EN).
// Latency: start bit drives o_Tx on the edge after i_Valid is accepted; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: o_Ready high when idle or in the last stop-bit cycle; a byte offered then follows with no gap.
// Ports: i_Clk, i_Rst (async, active high), i_Data/i_Valid in; o_Tx line, o_Ready, o_Done, o_Busy out.
// o_Done pulses one cycle before the stop bit ends so an upstream FSM can re-offer in time.
module uart_tx_byte
    import stopwatch_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_Data,
    input  logic       i_Valid,
    output logic       o_Tx,
    output logic       o_Ready,
    output logic       o_Done,
    output logic       o_Busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
`ifdef STOPWATCH_UART_PARITY_EN
    logic             par_q, par_d;
`endif

    logic bit_end;
    logic accept;

    assign bit_end = (cnt_q == CNT_LAST);
    assign o_Ready = (state_q == B_IDLE) || ((state_q == B_STOP) && bit_end);
    assign accept  = i_Valid && o_Ready;
    assign o_Done  = (state_q == B_STOP) && (cnt_q == CNT_DONE);
    assign o_Busy  = (state_q != B_IDLE);
    assign o_Tx    = tx_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
`ifdef STOPWATCH_UART_PARITY_EN
        par_d   = par_q;
`endif
        // Baud counter is held at 0 while idle and wraps at every bit boundary.
        cnt_d = ((state_q == B_IDLE) || bit_end) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            B_IDLE: begin
                if (accept) begin
                    state_d = B_START;
                    shreg_d = i_Data;
`ifdef STOPWATCH_UART_PARITY_EN
                    par_d   = ^i_Data;
`endif
                end
            end
            B_START: begin
                if (bit_end) begin
                    state_d = B_DATA;
                    bit_d   = 3'd0;
                end
            end
            B_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef STOPWATCH_UART_PARITY_EN
                        state_d = B_PARITY;
`else
                        state_d = B_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef STOPWATCH_UART_PARITY_EN
            B_PARITY: begin
                if (bit_end) state_d = B_STOP;
            end
`endif
            B_STOP: begin
                if (bit_end) begin
                    if (accept) begin
                        state_d = B_START;
                        shreg_d = i_Data;
`ifdef STOPWATCH_UART_PARITY_EN
                        par_d   = ^i_Data;
`endif
                    end else begin
                        state_d = B_IDLE;
                    end
                end
            end
            default: state_d = B_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (state_d)
            B_START:  tx_d = 1'b0;
            B_DATA:   tx_d = shreg_d[0];
`ifdef STOPWATCH_UART_PARITY_EN
            B_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
`ifdef STOPWATCH_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef STOPWATCH_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: rtl/stopwatch_uart_tx.sv
// Stopwatch serial reporter: sends "D2D1D0\r\n" over UART whenever the digits change or i_fReport pulses.
// Latency: start bit 1 cycle after the trigger is sampled; message is 50 (55 with parity) bit times.
// Backpressure: triggers during a message collapse into one pending report, sent right after.
// Ports: i_Clk, i_Rst (async, active high), i_Sec2..i_Sec0 BCD digits, i_fReport pulse; o_Tx line, o_Busy.
// Optional macro STOPWATCH_UART_PARITY_EN adds an even parity bit to every frame.
module stopwatch_uart_tx
    import stopwatch_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD  // must be >= 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Sec0,
    input  logic [3:0] i_Sec1,
    input  logic [3:0] i_Sec2,
    input  logic       i_fReport,
    output logic       o_Tx,
    output logic       o_Busy
);

    logic [11:0] digits;
    logic [1:0]  m_state_q, m_state_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] buf_q, buf_d;
    logic [11:0] snap_q, snap_d;
    logic        pending_q, pending_d;

    logic       trig;
    logic       start;
    logic       tx_valid;
    logic [7:0] tx_char;
    logic       tx_ready;
    logic       tx_done;

    assign digits = {i_Sec2, i_Sec1, i_Sec0};

    always_comb begin
        trig      = i_fReport || (digits != snap_q);
        start     = (m_state_q == M_IDLE) && (trig || pending_q);
        snap_d    = trig ? digits : snap_q;
        // A trigger arriving together with a start is served by that same message.
        pending_d = start ? 1'b0 : (trig ? 1'b1 : pending_q);

        m_state_d = m_state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        tx_valid  = 1'b0;

        case (m_state_q)
            M_IDLE: begin
                if (start) begin
                    m_state_d = M_SEND;
                    idx_d     = 3'd0;
                    buf_d     = digits;
                end
            end
            M_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) m_state_d = M_WAIT;
            end
            M_WAIT: begin
                // tx_done fires one cycle early, so M_SEND lands on the serializer's
                // final stop cycle and the next start bit follows without a gap.
                if (tx_done) begin
                    if (idx_q == 3'(MSG_LEN - 1)) begin
                        m_state_d = M_IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        m_state_d = M_SEND;
                    end
                end
            end
            default: m_state_d = M_IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            3'd0:    tx_char = digit_to_ascii(buf_q[11:8]);
            3'd1:    tx_char = digit_to_ascii(buf_q[7:4]);
            3'd2:    tx_char = digit_to_ascii(buf_q[3:0]);
            3'd3:    tx_char = ASCII_CR;
            default: tx_char = ASCII_LF;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            m_state_q <= M_IDLE;
            idx_q     <= 3'd0;
            buf_q     <= 12'h000;
            snap_q    <= 12'h000;
            pending_q <= 1'b0;
        end else begin
            m_state_q <= m_state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Data  (tx_char),
        .i_Valid (tx_valid),
        .o_Tx    (o_Tx),
        .o_Ready (tx_ready),
        .o_Done  (tx_done),
        .o_Busy  (o_Busy)
    );

endmodule
